// File: rtl/dmem_pkg.sv
// Shared constants and address decode for the data-side memory responder.
// Used by the top level and the timer.
package dmem_pkg;

  localparam logic [31:0] ADDR_LED   = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_COUNT = 32'hFFFF_FFF1;
  localparam logic [31:0] ADDR_CMP   = 32'hFFFF_FFF2;
  localparam logic [31:0] ADDR_CTRL  = 32'hFFFF_FFF3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_PEND  = 2;

  localparam logic [3:0] RAM_TAG = 4'h0;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_RAM   = 3'd1,
    SEL_LED   = 3'd2,
    SEL_COUNT = 3'd3,
    SEL_CMP   = 3'd4,
    SEL_CTRL  = 3'd5
  } sel_e;

  // Word-address decode; anything outside RAM and the four MMIO words is unmapped.
  function automatic sel_e decode(input logic [31:0] a);
    sel_e s;
    if (a[31:28] == RAM_TAG) begin
      s = SEL_RAM;
    end else begin
      case (a)
        ADDR_LED:   s = SEL_LED;
        ADDR_COUNT: s = SEL_COUNT;
        ADDR_CMP:   s = SEL_CMP;
        ADDR_CTRL:  s = SEL_CTRL;
        default:    s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Data port between the datapath (master) and the memory responder (slave).
interface dmem_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/dmem_mmio_timer.sv
// Compare/auto-reload timer: COUNT, COMPARE and CTRL registers with a
// sticky pending flag and a registered interrupt output.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_cmp,
  input  logic        we_ctrl,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [31:0] ctrl,
  output logic        irq
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        en_r;
  logic        irqen_r;
  logic        pend_r;
  logic        irq_r;

  logic [31:0] count_nxt_s;
  logic        en_nxt_s;
  logic        irqen_nxt_s;
  logic        pend_nxt_s;
  logic        match_s;

  // Next-state: a CPU write to COUNT suppresses the match check that cycle; set beats W1C.
  always_comb begin
    match_s     = en_r && (count_r == compare_r) && !we_count;
    count_nxt_s = count_r;
    en_nxt_s    = en_r;
    irqen_nxt_s = irqen_r;
    pend_nxt_s  = pend_r;
    if (we_count) begin
      count_nxt_s = wdata;
    end else if (match_s) begin
      count_nxt_s = 32'h0000_0000;
    end else if (en_r) begin
      count_nxt_s = count_r + 32'h0000_0001;
    end else begin
      count_nxt_s = count_r;
    end
    if (we_ctrl) begin
      en_nxt_s    = wdata[CTRL_EN];
      irqen_nxt_s = wdata[CTRL_IRQEN];
    end else begin
      en_nxt_s    = en_r;
      irqen_nxt_s = irqen_r;
    end
    if (match_s) begin
      pend_nxt_s = 1'b1;
    end else if (we_ctrl && wdata[CTRL_PEND]) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Timer state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= 32'h0000_0000;
      compare_r <= 32'hFFFF_FFFF;
      en_r      <= 1'b0;
      irqen_r   <= 1'b0;
      pend_r    <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      compare_r <= we_cmp ? wdata : compare_r;
      en_r      <= en_nxt_s;
      irqen_r   <= irqen_nxt_s;
      pend_r    <= pend_nxt_s;
      irq_r     <= pend_nxt_s && irqen_nxt_s;
    end
  end

  assign count   = count_r;
  assign compare = compare_r;
  assign ctrl    = {29'd0, pend_r, irqen_r, en_r};
  assign irq     = irq_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word-addressed RAM, LED register and timer
// behind a combinational read port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_AW = 6,
  parameter int LED_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_if.slave            bus,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;

  logic [31:0]       mem_r [RAM_DEPTH];
  logic [LED_W-1:0]  led_r;
  logic [RAM_AW-1:0] idx_s;
  sel_e              sel_s;
  logic [31:0]       t_count_s;
  logic [31:0]       t_cmp_s;
  logic [31:0]       t_ctrl_s;

  assign sel_s = decode(bus.addr);
  assign idx_s = bus.addr[RAM_AW-1:0];

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.memwrite && (sel_s == SEL_RAM)) begin
      mem_r[idx_s] <= bus.writedata;
    end
  end

  // LED output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= {LED_W{1'b0}};
    end else if (bus.memwrite && (sel_s == SEL_LED)) begin
      led_r <= bus.writedata[LED_W-1:0];
    end else begin
      led_r <= led_r;
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .we_count (bus.memwrite && (sel_s == SEL_COUNT)),
    .we_cmp   (bus.memwrite && (sel_s == SEL_CMP)),
    .we_ctrl  (bus.memwrite && (sel_s == SEL_CTRL)),
    .wdata    (bus.writedata),
    .count    (t_count_s),
    .compare  (t_cmp_s),
    .ctrl     (t_ctrl_s),
    .irq      (irq)
  );

  // Zero-latency read mux; a same-cycle write is not yet visible here.
  always_comb begin
    bus.readdata = 32'h0000_0000;
    case (sel_s)
      SEL_RAM:   bus.readdata = mem_r[idx_s];
      SEL_LED:   bus.readdata = {{(32-LED_W){1'b0}}, led_r};
      SEL_COUNT: bus.readdata = t_count_s;
      SEL_CMP:   bus.readdata = t_cmp_s;
      SEL_CTRL:  bus.readdata = t_ctrl_s;
      default:   bus.readdata = 32'h0000_0000;
    endcase
  end

  assign leds = led_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: stimulus pushes expected read/led/irq values from a
// behavioural model; a negedge monitor pops and compares.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();
  logic [7:0] leds;
  logic       irq;

  dmem_responder #(.RAM_AW(6), .LED_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds),
    .irq   (irq)
  );

  typedef struct {
    logic [31:0] rd;
    logic [7:0]  led;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_req = 1'b0;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_val [64];
  logic [7:0]  m_led;
  logic [31:0] m_count, m_cmp;
  bit          m_en, m_irqen, m_pend, m_irq;

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:28] == 4'h0;
  endfunction

  function automatic bit known(input logic [31:0] a);
    return !is_ram(a) || m_val[a[5:0]];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_ram(a))           return m_ram[a[5:0]];
    else if (a == ADDR_LED)  return {24'd0, m_led};
    else if (a == ADDR_COUNT) return m_count;
    else if (a == ADDR_CMP)  return m_cmp;
    else if (a == ADDR_CTRL) return {29'd0, m_pend, m_irqen, m_en};
    else                     return 32'd0;
  endfunction

  task automatic model_reset();
    m_led = 8'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_en = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
  endtask

  // Advance the model across one rising edge given the bus inputs of that cycle.
  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit cnt_wr, ctrl_wr, hit;
    logic [31:0] nc;
    bit np;
    cnt_wr  = we && (a == ADDR_COUNT);
    ctrl_wr = we && (a == ADDR_CTRL);
    hit = m_en && !cnt_wr && (m_count == m_cmp);
    if (cnt_wr)     nc = wd;
    else if (hit)   nc = 32'd0;
    else if (m_en)  nc = m_count + 32'd1;
    else            nc = m_count;
    np = hit ? 1'b1 : ((ctrl_wr && wd[2]) ? 1'b0 : m_pend);
    if (ctrl_wr) begin m_en = wd[0]; m_irqen = wd[1]; end
    if (we && a == ADDR_CMP) m_cmp = wd;
    if (we && a == ADDR_LED) m_led = wd[7:0];
    if (we && is_ram(a)) begin m_ram[a[5:0]] = wd; m_val[a[5:0]] = 1'b1; end
    m_count = nc;
    m_pend  = np;
    m_irq   = m_pend && m_irqen;
  endtask

  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t e;
    bit chk;
    @(posedge clk); #1;
    bus.memwrite  = we;
    bus.addr      = a;
    bus.writedata = wd;
    chk = known(a);
    if (chk) begin
      e.rd = model_read(a); e.led = m_led; e.irq = m_irq; e.tag = tag;
      exp_q.push_back(e);
    end
    chk_req = chk;
    model_step(we, a, wd);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    cycle(1'b0, a, 32'd0, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    cycle(1'b1, a, d, tag);
  endtask

  task automatic chk_now(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, req);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        e = exp_q.pop_front();
        if (bus.readdata !== e.rd || leds !== e.led || irq !== e.irq) begin
          errors++;
          $display("FAIL %s: got rd=%h leds=%h irq=%b, expected rd=%h leds=%h irq=%b",
                   e.tag, bus.readdata, leds, irq, e.rd, e.led, e.irq);
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1: return {4'h0, 22'($urandom), 6'($urandom)};
      2:    return ADDR_LED;
      3:    return ADDR_COUNT;
      4:    return ADDR_CMP;
      5:    return ADDR_CTRL;
      default: return 32'h2000_0000 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bus.memwrite = 1'b0; bus.addr = 32'd0; bus.writedata = 32'd0;
    for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state of the MMIO window
    rd(ADDR_LED, "rst_led"); rd(ADDR_COUNT, "rst_count");
    rd(ADDR_CMP, "rst_cmp"); rd(ADDR_CTRL, "rst_ctrl");

    // RAM store/load, alias, unmapped
    wr(32'd0, 32'h1111_2222, "ram0_wr");
    wr(32'd5, 32'hDEAD_BEEF, "ram5_wr");
    rd(32'd5, "ram5_rd"); rd(32'h45, "ram_alias");
    rd(32'h2000_0000, "unmapped_rd");
    wr(32'h2000_0000, 32'h5555_5555, "unmapped_wr");
    rd(32'd0, "ram0_intact");
    rd(32'h0FFF_FFC5, "ram_alias_hi");

    // Same-cycle read/write
    wr(32'd10, 32'd1, "rw_setup");
    wr(32'd10, 32'd2, "rw_old");
    rd(32'd10, "rw_new");

    // Timer match and reload
    wr(ADDR_CMP, 32'd3, "cmp_wr");
    wr(ADDR_CTRL, 32'd3, "ctrl_wr");
    for (int i = 0; i < 6; i++) rd(ADDR_COUNT, "timer_seq");
    rd(ADDR_CTRL, "ctrl_pend");
    wr(ADDR_CTRL, 32'd7, "w1c");
    rd(ADDR_CTRL, "ctrl_after_w1c");

    // COUNT write collision
    wr(ADDR_COUNT, 32'd100, "count_wr");
    rd(ADDR_COUNT, "count_100");
    rd(ADDR_COUNT, "count_101");

    // W1C on the match edge: set wins
    wr(ADDR_COUNT, 32'd0, "count_zero");
    for (int i = 0; i < 10 && m_count != m_cmp; i++) rd(ADDR_COUNT, "to_match");
    chk_now("reach_match", m_count, m_cmp);
    wr(ADDR_CTRL, 32'd7, "w1c_on_match");
    rd(ADDR_CTRL, "pend_set_wins");

    // Wrap without flag
    wr(ADDR_CMP, 32'd50, "cmp_50");
    wr(ADDR_CTRL, 32'd7, "clr_pend");
    wr(ADDR_COUNT, 32'hFFFF_FFFE, "count_near_wrap");
    for (int i = 0; i < 4; i++) rd(ADDR_COUNT, "wrap_seq");
    rd(ADDR_CTRL, "wrap_no_pend");

    // Async reset mid-count
    wr(ADDR_LED, 32'h0000_00A5, "led_wr");
    wr(ADDR_CMP, 32'd4, "cmp_4");
    wr(ADDR_COUNT, 32'd7, "count_7");
    wr(ADDR_COUNT, 32'd0, "count_0");
    for (int i = 0; i < 10 && !m_irq; i++) rd(ADDR_COUNT, "to_irq");
    wr(ADDR_COUNT, 32'd7, "count_7b");
    @(posedge clk); #1;
    chk_req = 1'b0;
    bus.memwrite = 1'b0; bus.addr = ADDR_COUNT;
    chk_now("pre_reset_count", bus.readdata, m_count);
    chk_now("pre_reset_leds", {24'd0, leds}, 32'h0000_00A5);
    chk_now("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_now("areset_count", bus.readdata, 32'd0);
    chk_now("areset_leds", {24'd0, leds}, 32'd0);
    chk_now("areset_irq", {31'd0, irq}, 32'd0);
    #1 reset = 1'b0;
    model_reset();
    rd(32'd5, "ram_survives_reset");
    rd(ADDR_CMP, "cmp_after_reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      a = rand_addr();
      if (a == ADDR_CMP)        d = 32'($urandom_range(0, 20));
      else if (a == ADDR_COUNT) d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 20));
      else if (a == ADDR_CTRL)  d = 32'($urandom_range(0, 7));
      else                      d = $urandom;
      cycle(1'($urandom_range(0, 1)), a, d, "random");
    end

    @(posedge clk); #1;
    chk_req = 1'b0;
    bus.memwrite = 1'b0;
    chk_now("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
